// File: rtl/aes_io_pkg.sv
// Shared types and constants for the AES byte-serial I/O sequencer.
// Optional CBC chaining is enabled by defining AES_IO_CBC_EN.
package aes_io_pkg;

  localparam int BLOCK_BYTES = 16;
  localparam int CNT_W       = 5;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BLOCK_BYTES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    UNLOAD = 2'd2
  } state_t;

endpackage

// File: rtl/aes_io_edge_sync.sv
// Pin strobe synchroniser: SYNC_STAGES flops plus a previous-value flop,
// producing a one-cycle pulse on each synchronised 0->1 transition.
module aes_io_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // Keeps sampling regardless of the design enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/aes_io_sequencer.sv
// Byte-serial key/plaintext loader, AES core starter and ciphertext unloader.
// Define AES_IO_CBC_EN to chain blocks (CBC, IV = 0); default build is ECB.
module aes_io_sequencer
  import aes_io_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ena,
  input  logic [7:0]   in_byte,
  input  logic         in_valid,
  input  logic         in_is_key,
  input  logic         out_ready,
  output logic [7:0]   out_byte,
  output logic         out_valid,
  output logic         busy,
  output logic         ovf,
  output logic         core_start,
  output logic [127:0] core_key,
  output logic [127:0] core_pt,
  input  logic         core_done,
  input  logic [127:0] core_ct
);

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_key_cnt, w_key_cnt_nxt;
  logic [CNT_W-1:0]   r_pt_cnt, w_pt_cnt_nxt;
  logic [CNT_W-1:0]   r_out_cnt, w_out_cnt_nxt;
  logic               r_key_used, w_key_used_nxt;
  logic [127:0]       r_key, w_key_nxt;
  logic [127:0]       r_pt, w_pt_nxt;
  logic [127:0]       r_ct, w_ct_nxt;
  logic               r_ovf, w_ovf_nxt;
  logic               w_start;
  logic               w_in_ev;
  logic               w_out_ev;
`ifdef AES_IO_CBC_EN
  logic [127:0]       r_chain, w_chain_nxt;
`endif

  aes_io_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_in_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pin  (in_valid),
    .o_rise (w_in_ev)
  );

  aes_io_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_out_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_pin  (out_ready),
    .o_rise (w_out_ev)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= LOAD;
      r_key_cnt  <= '0;
      r_pt_cnt   <= '0;
      r_out_cnt  <= '0;
      r_key_used <= 1'b0;
      r_key      <= '0;
      r_pt       <= '0;
      r_ct       <= '0;
      r_ovf      <= 1'b0;
`ifdef AES_IO_CBC_EN
      r_chain    <= '0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_key_cnt  <= w_key_cnt_nxt;
      r_pt_cnt   <= w_pt_cnt_nxt;
      r_out_cnt  <= w_out_cnt_nxt;
      r_key_used <= w_key_used_nxt;
      r_key      <= w_key_nxt;
      r_pt       <= w_pt_nxt;
      r_ct       <= w_ct_nxt;
      r_ovf      <= w_ovf_nxt;
`ifdef AES_IO_CBC_EN
      r_chain    <= w_chain_nxt;
`endif
    end
  end

  // Valid/ready: out_valid stays high in UNLOAD; each synchronised out_ready
  // rise consumes the presented byte. in_valid rises are accepted only in LOAD.
  always_comb begin
    w_state_nxt    = r_state;
    w_key_cnt_nxt  = r_key_cnt;
    w_pt_cnt_nxt   = r_pt_cnt;
    w_out_cnt_nxt  = r_out_cnt;
    w_key_used_nxt = r_key_used;
    w_key_nxt      = r_key;
    w_pt_nxt       = r_pt;
    w_ct_nxt       = r_ct;
    w_ovf_nxt      = r_ovf;
    w_start        = 1'b0;
`ifdef AES_IO_CBC_EN
    w_chain_nxt    = r_chain;
`endif
    if (ena) begin
      case (r_state)
        LOAD: begin
          if (r_key_cnt == CNT_FULL && r_pt_cnt == CNT_FULL) begin
            w_start        = 1'b1;
            w_pt_cnt_nxt   = '0;
            w_key_used_nxt = 1'b1;
            w_state_nxt    = RUN;
            if (w_in_ev) w_ovf_nxt = 1'b1;
          end else if (w_in_ev) begin
            if (in_is_key) begin
              if (r_key_cnt != CNT_FULL) begin
                w_key_nxt     = {r_key[119:0], in_byte};
                w_key_cnt_nxt = r_key_cnt + CNT_ONE;
`ifdef AES_IO_CBC_EN
                if (r_key_cnt == CNT_LAST) w_chain_nxt = '0;
`endif
              end else if (r_key_used) begin
                // A key byte after a completed block starts a fresh key.
                w_key_nxt      = {r_key[119:0], in_byte};
                w_key_cnt_nxt  = CNT_ONE;
                w_key_used_nxt = 1'b0;
              end else begin
                w_ovf_nxt = 1'b1;
              end
            end else if (r_pt_cnt != CNT_FULL) begin
              w_pt_nxt     = {r_pt[119:0], in_byte};
              w_pt_cnt_nxt = r_pt_cnt + CNT_ONE;
            end else begin
              w_ovf_nxt = 1'b1;
            end
          end
        end
        RUN: begin
          if (w_in_ev) w_ovf_nxt = 1'b1;
          if (core_done) begin
            w_ct_nxt      = core_ct;
            w_out_cnt_nxt = '0;
            w_state_nxt   = UNLOAD;
`ifdef AES_IO_CBC_EN
            w_chain_nxt   = core_ct;
`endif
          end
        end
        UNLOAD: begin
          if (w_in_ev) w_ovf_nxt = 1'b1;
          if (w_out_ev) begin
            w_ct_nxt      = {r_ct[119:0], 8'h00};
            w_out_cnt_nxt = r_out_cnt + CNT_ONE;
            if (r_out_cnt == CNT_LAST) w_state_nxt = LOAD;
          end
        end
        default: w_state_nxt = LOAD;
      endcase
    end
  end

  assign core_start = w_start;
  assign busy       = (r_state == RUN) || (r_state == UNLOAD);
  assign out_valid  = (r_state == UNLOAD);
  assign out_byte   = out_valid ? r_ct[127:120] : 8'h00;
  assign ovf        = r_ovf;
  assign core_key   = r_key;
`ifdef AES_IO_CBC_EN
  assign core_pt    = r_pt ^ r_chain;
`else
  assign core_pt    = r_pt;
`endif

endmodule

// File: tb/tb_aes_io_sequencer.sv
// Randomised self-checking bench for aes_io_sequencer with a core stub and
// a transaction-level reference model. Honours AES_IO_CBC_EN when defined.
module tb_aes_io_sequencer;

  localparam int SYNC = 2;
  localparam int HOLD = SYNC + 3;
  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst_n, ena, in_valid, in_is_key, out_ready;
  logic [7:0]   in_byte, out_byte;
  logic         out_valid, busy, ovf, core_start, core_done;
  logic [127:0] core_key, core_pt, core_ct;

  always #5 clk = ~clk;

  aes_io_sequencer #(.SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .in_byte    (in_byte),
    .in_valid   (in_valid),
    .in_is_key  (in_is_key),
    .out_ready  (out_ready),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .busy       (busy),
    .ovf        (ovf),
    .core_start (core_start),
    .core_key   (core_key),
    .core_pt    (core_pt),
    .core_done  (core_done),
    .core_ct    (core_ct)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- AES core stub ----------------
  int           start_cycles = 0;
  int           stub_lat = 11;
  logic [127:0] stub_ct, cap_key, cap_pt;

  always @(negedge clk) if (core_start === 1'b1) start_cycles++;

  initial begin
    core_done = 1'b0;
    core_ct   = '0;
    cap_key   = '0;
    cap_pt    = '0;
    forever begin
      @(negedge clk);
      if (core_start === 1'b1) begin
        cap_key = core_key;
        cap_pt  = core_pt;
        repeat (stub_lat - 1) @(negedge clk);
        core_ct   = stub_ct;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        core_ct   = '0;
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  int           m_kc, m_pc, m_starts;
  bit           m_key_used, m_busy, m_ovf;
  logic [127:0] m_key, m_pt, m_chain, m_exp_key, m_exp_pt;
  logic [7:0]   exp_q[$];

  function automatic logic [127:0] model_core_pt();
`ifdef AES_IO_CBC_EN
    return m_pt ^ m_chain;
`else
    return m_pt;
`endif
  endfunction

  function automatic void model_reset();
    m_kc = 0; m_pc = 0; m_starts = 0;
    m_key_used = 0; m_busy = 0; m_ovf = 0;
    m_key = '0; m_pt = '0; m_chain = '0;
    exp_q.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b, input bit k);
    if (m_busy) begin
      m_ovf = 1;
    end else if (k) begin
      if (m_kc < 16) begin
        m_key = {m_key[119:0], b};
        m_kc++;
        if (m_kc == 16) m_chain = '0;
      end else if (m_key_used) begin
        m_key = {m_key[119:0], b};
        m_kc = 1;
        m_key_used = 0;
      end else begin
        m_ovf = 1;
      end
    end else if (m_pc < 16) begin
      m_pt = {m_pt[119:0], b};
      m_pc++;
    end else begin
      m_ovf = 1;
    end
    if (!m_busy && m_kc == 16 && m_pc == 16) begin
      m_starts++;
      m_exp_key = m_key;
      m_exp_pt  = model_core_pt();
      m_pc = 0;
      m_key_used = 1;
      m_busy = 1;
      for (int i = 0; i < 16; i++) exp_q.push_back(stub_ct[127-8*i -: 8]);
      m_chain = stub_ct;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b, input bit k);
    in_byte   = b;
    in_is_key = k;
    in_valid  = 1'b1;
    repeat (HOLD) @(negedge clk);
    in_valid  = 1'b0;
    repeat (HOLD) @(negedge clk);
    if (ena) model_byte(b, k);
  endtask

  task automatic ack_byte();
    out_ready = 1'b1;
    repeat (HOLD) @(negedge clk);
    out_ready = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  // order: 0 = keys first, 1 = alternating k,p, 2 = random interleave
  task automatic load_block(input bit with_key, input logic [127:0] key,
                            input logic [127:0] pt, input int order);
    logic [7:0] bq[$];
    bit         kq[$];
    int ki = 0;
    int pi = 0;
    int nk = with_key ? 16 : 0;
    bit take_key;
    while (ki < nk || pi < 16) begin
      if (ki >= nk)        take_key = 0;
      else if (pi >= 16)   take_key = 1;
      else if (order == 0) take_key = 1;
      else if (order == 1) take_key = (ki == pi);
      else                 take_key = 1'($urandom_range(0, 1));
      if (take_key) begin bq.push_back(key[127-8*ki -: 8]); kq.push_back(1); ki++; end
      else          begin bq.push_back(pt[127-8*pi -: 8]);  kq.push_back(0); pi++; end
    end
    for (int i = 0; i < bq.size(); i++) begin
      if (i == bq.size() - 1) check_eq("no_early_start", 128'(start_cycles), 128'(m_starts));
      send_byte(bq[i], kq[i]);
    end
  endtask

  task automatic check_block();
    check_eq("start_count", 128'(start_cycles), 128'(m_starts));
    check_eq("core_key", cap_key, m_exp_key);
    check_eq("core_pt", cap_pt, m_exp_pt);
    check_eq("busy_run", 128'(busy), 128'(m_busy));
  endtask

  task automatic unload(input int n);
    int guard = 0;
    while (out_valid !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq("out_valid_wait", 128'(out_valid), 128'(1));
    for (int i = 0; i < n; i++) begin
      check_eq("out_byte", 128'(out_byte), 128'(exp_q.size() > 0 ? exp_q.pop_front() : 8'hxx));
      ack_byte();
    end
    if (n == 16) begin
      m_busy = 0;
      check_eq("out_valid_end", 128'(out_valid), 128'(0));
      check_eq("busy_end", 128'(busy), 128'(0));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- test sequence ----------------
  logic [127:0] rk, rp;
  bit           wk;

  initial begin
    rst_n = 1'b0; ena = 1'b1; in_byte = '0; in_valid = 1'b0;
    in_is_key = 1'b0; out_ready = 1'b0; stub_ct = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_eq("rst_out_valid", 128'(out_valid), 128'(0));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_ovf", 128'(ovf), 128'(0));
    check_eq("rst_start", 128'(core_start), 128'(0));
    check_eq("rst_key", core_key, 128'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Known vector, key then plaintext
    stub_ct = CT1;
    load_block(1, KEY1, PT1, 0);
    check_block();
    unload(16);

    // Interleaved reload of the same key and plaintext
    load_block(1, KEY1, PT1, 1);
    check_block();
    unload(16);

    // Second block, no new key, identical plaintext
    load_block(0, KEY1, PT1, 0);
    check_block();
    unload(16);

    // 17th plaintext byte while key is incomplete
    stub_ct = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1);
    for (int i = 0; i < 16; i++) send_byte(8'($urandom), 0);
    send_byte(8'hee, 0);
    check_eq("ovf_pt17", 128'(ovf), 128'(m_ovf));
    check_eq("key_hold", core_key, m_key);
    check_eq("pt_hold", core_pt, model_core_pt());
    for (int i = 0; i < 11; i++) send_byte(8'($urandom), 1);
    check_block();
    unload(16);

    // Reset during UNLOAD after 5 acks
    stub_ct = {$urandom, $urandom, $urandom, $urandom};
    load_block(0, KEY1, {$urandom, $urandom, $urandom, $urandom}, 2);
    check_block();
    unload(5);
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 128'(out_valid), 128'(0));
    check_eq("arst_busy", 128'(busy), 128'(0));
    check_eq("arst_ovf", 128'(ovf), 128'(0));
    check_eq("arst_key", core_key, 128'(0));
    check_eq("arst_pt", core_pt, 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    start_cycles = 0;
    @(negedge clk);

    // Bytes in RUN and UNLOAD are rejected
    stub_lat = 30;
    stub_ct  = {$urandom, $urandom, $urandom, $urandom};
    rk = {$urandom, $urandom, $urandom, $urandom};
    load_block(1, rk, {$urandom, $urandom, $urandom, $urandom}, 2);
    send_byte(8'h5a, 1);
    check_eq("ovf_run", 128'(ovf), 128'(m_ovf));
    check_eq("key_run", core_key, rk);
    check_block();
    stub_lat = 11;
    unload(16);

    // ena low: strobe is lost and nothing changes
    ena = 1'b0;
    send_byte(8'h77, 0);
    ena = 1'b1;
    check_eq("ena_key", core_key, m_key);
    check_eq("ena_pt", core_pt, model_core_pt());

    // Randomised blocks
    for (int r = 0; r < 5; r++) begin
      wk = 1'($urandom_range(0, 1));
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      stub_ct = {$urandom, $urandom, $urandom, $urandom};
      load_block(wk, rk, rp, 2);
      check_block();
      unload(16);
      check_eq("ovf_rand", 128'(ovf), 128'(m_ovf));
    end

    check_eq("exp_q_empty", 128'(exp_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
